// File: rtl/cpu_pkg.sv
// Shared RV32I decode definitions: opcode and function-field constants, ALU/writeback
// encodings, buffer states and the packed decoded bundle.
package cpu_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_NOP = 5'd0, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    // Immediate is kept at 32 bits here; the stage sign-extends it to XLEN.
    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_e     alu_op;
        wb_sel_e     wb_sel;
        logic        reg_we;
        logic        mem_we;
        logic        mem_re;
        logic        branch;
        logic        jump;
        logic        illegal;
    } decoded_t;

    function automatic alu_op_e base_alu_op(input logic [2:0] f3);
        unique case (f3)
            F3_ADD:  return ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return ALU_SRL;
            F3_OR:   return ALU_OR;
            F3_AND:  return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_e muldiv_alu_op(input logic [2:0] f3);
        unique case (f3)
            3'd0: return ALU_MUL;
            3'd1: return ALU_MULH;
            3'd2: return ALU_MULHSU;
            3'd3: return ALU_MULHU;
            3'd4: return ALU_DIV;
            3'd5: return ALU_DIVU;
            3'd6: return ALU_REM;
            3'd7: return ALU_REMU;
        endcase
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I decoder: raw instruction to decoded_t bundle.
// Define DECODE_RV32M_EN to accept the M-extension (MUL..REMU) encodings.
module decode_comb
    import cpu_pkg::*;
(
    input  logic [31:0] instr_i,
    output decoded_t    dec_o
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic        legal;
    logic        writes_rd;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];
    assign rd     = instr_i[11:7];

    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u  = {instr_i[31:12], 12'b0};
    assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign imm_sh = {27'b0, instr_i[24:20]};

    always_comb begin
        dec_o        = '0;
        dec_o.opcode = opcode;
        dec_o.funct3 = f3;
        dec_o.rs1    = instr_i[19:15];
        dec_o.rs2    = instr_i[24:20];
        dec_o.rd     = rd;
        legal        = 1'b1;
        writes_rd    = 1'b0;

        unique case (opcode)
            OP_LUI: begin
                dec_o.rs1 = '0;
                dec_o.imm = imm_u; dec_o.alu_op = ALU_ADD; writes_rd = 1'b1;
            end
            OP_AUIPC: begin
                dec_o.imm = imm_u; dec_o.alu_op = ALU_ADD; writes_rd = 1'b1;
            end
            OP_JAL: begin
                dec_o.imm = imm_j; dec_o.alu_op = ALU_ADD; dec_o.wb_sel = WB_PC4;
                dec_o.jump = 1'b1; writes_rd = 1'b1;
            end
            OP_JALR: begin
                dec_o.imm = imm_i; dec_o.alu_op = ALU_ADD; dec_o.wb_sel = WB_PC4;
                dec_o.jump = 1'b1; writes_rd = 1'b1;
                legal = (f3 == 3'b000);
            end
            OP_BRANCH: begin
                dec_o.imm = imm_b; dec_o.branch = 1'b1;
                unique case (f3)
                    3'b000, 3'b001: dec_o.alu_op = ALU_SUB;
                    3'b100, 3'b101: dec_o.alu_op = ALU_SLT;
                    3'b110, 3'b111: dec_o.alu_op = ALU_SLTU;
                    default:        legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                dec_o.imm = imm_i; dec_o.alu_op = ALU_ADD; dec_o.wb_sel = WB_MEM;
                dec_o.mem_re = 1'b1; writes_rd = 1'b1;
                legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                        (f3 == 3'b100) || (f3 == 3'b101);
            end
            OP_STORE: begin
                dec_o.imm = imm_s; dec_o.alu_op = ALU_ADD; dec_o.mem_we = 1'b1;
                legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
            end
            OP_IMM: begin
                writes_rd    = 1'b1;
                dec_o.alu_op = base_alu_op(f3);
                dec_o.imm    = imm_i;
                // Shift-immediates carry the shamt zero-extended and encode SRA in funct7.
                if (f3 == F3_SLL) begin
                    dec_o.imm = imm_sh;
                    legal     = (f7 == F7_BASE);
                end else if (f3 == F3_SR) begin
                    dec_o.imm = imm_sh;
                    legal     = (f7 == F7_BASE) || (f7 == F7_ALT);
                    if (f7 == F7_ALT) dec_o.alu_op = ALU_SRA;
                end
            end
            OP_REG: begin
                writes_rd = 1'b1;
                unique case (f7)
                    F7_BASE: dec_o.alu_op = base_alu_op(f3);
                    F7_ALT: begin
                        if (f3 == F3_ADD)     dec_o.alu_op = ALU_SUB;
                        else if (f3 == F3_SR) dec_o.alu_op = ALU_SRA;
                        else                  legal = 1'b0;
                    end
`ifdef DECODE_RV32M_EN
                    F7_MULDIV: dec_o.alu_op = muldiv_alu_op(f3);
`endif
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase

        if (instr_i[1:0] != 2'b11) legal = 1'b0;

        if (!legal) begin
            dec_o.imm     = '0;
            dec_o.alu_op  = ALU_NOP;
            dec_o.wb_sel  = WB_ALU;
            dec_o.mem_we  = 1'b0;
            dec_o.mem_re  = 1'b0;
            dec_o.branch  = 1'b0;
            dec_o.jump    = 1'b0;
            dec_o.illegal = 1'b1;
            writes_rd     = 1'b0;
        end

        dec_o.reg_we = writes_rd && (rd != 5'd0);
    end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: OUT register plus one-entry skid buffer, valid/ready
// on both sides, flush, and sign-extension of the immediate to XLEN.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_alu_op,
    output logic [1:0]      out_wb_sel,
    output logic            out_reg_we,
    output logic            out_mem_we,
    output logic            out_mem_re,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_illegal,
    output logic [1:0]      dbg_state
);

    // Handshake: a beat moves on either side exactly when valid && ready at the rising edge;
    // in_ready is a function of registered state only, never of out_ready.
    buf_state_e      state_q, state_d;
    decoded_t        dec;
    decoded_t        out_q, out_d, skid_q, skid_d;
    logic [PC_W-1:0] out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
    logic            accept;

    decode_comb u_decode_comb (
        .instr_i (in_instr),
        .dec_o   (dec)
    );

    assign in_ready  = (state_q != BUF_FULL) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q != BUF_EMPTY);
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        out_pc_d  = out_pc_q;
        skid_d    = skid_q;
        skid_pc_d = skid_pc_q;
        unique case (state_q)
            BUF_EMPTY: begin
                if (accept) begin
                    out_d = dec; out_pc_d = in_pc; state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (accept && out_ready) begin
                    out_d = dec; out_pc_d = in_pc;
                end else if (accept) begin
                    skid_d = dec; skid_pc_d = in_pc; state_d = BUF_FULL;
                end else if (out_ready) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (out_ready) begin
                    out_d = skid_q; out_pc_d = skid_pc_q; state_d = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        if (flush) state_d = BUF_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BUF_EMPTY;
            out_q     <= '0;
            out_pc_q  <= '0;
            skid_q    <= '0;
            skid_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            out_pc_q  <= out_pc_d;
            skid_q    <= skid_d;
            skid_pc_q <= skid_pc_d;
        end
    end

    assign out_pc      = out_pc_q;
    assign out_opcode  = out_q.opcode;
    assign out_funct3  = out_q.funct3;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rd      = out_q.rd;
    assign out_imm     = XLEN'($signed(out_q.imm));
    assign out_alu_op  = out_q.alu_op;
    assign out_wb_sel  = out_q.wb_sel;
    assign out_reg_we  = out_q.reg_we;
    assign out_mem_we  = out_q.mem_we;
    assign out_mem_re  = out_q.mem_re;
    assign out_branch  = out_q.branch;
    assign out_jump    = out_q.jump;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed steps then randomized traffic, checked against a
// reference decoder and a queue holding what the stage should contain.
module tb_decode_stage;
  import cpu_pkg::*;

  localparam int EW = 102;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1, out_rs2, out_rd, out_alu_op;
  logic [1:0]  out_wb_sel, dbg_state;
  logic        out_reg_we, out_mem_we, out_mem_re, out_branch, out_jump, out_illegal;
  logic [EW-1:0] obs_bundle;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] pc_ctr = 32'h1000;

  // clock / reset block
  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_wb_sel(out_wb_sel), .out_reg_we(out_reg_we),
    .out_mem_we(out_mem_we), .out_mem_re(out_mem_re), .out_branch(out_branch),
    .out_jump(out_jump), .out_illegal(out_illegal), .dbg_state(dbg_state)
  );

  assign obs_bundle = {out_pc, out_opcode, out_funct3, out_rs1, out_rs2, out_rd, out_imm,
                       out_alu_op, out_wb_sel, out_reg_we, out_mem_we, out_mem_re,
                       out_branch, out_jump, out_illegal};

  // Reference decoder written from the ISA rules, returning the expected output bundle.
  function automatic logic [EW-1:0] ref_bundle(input logic [31:0] ins, input logic [31:0] pc);
    int base_alu[8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    int op, f3, f7, alu, wb;
    longint imm;
    bit ok, wr, mw, mr, br, jp;
    logic [4:0] rs1, rd;
    op = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]);
    rs1 = ins[19:15]; rd = ins[11:7];
    imm = 0; alu = ALU_NOP; wb = 0;
    ok = 0; wr = 0; mw = 0; mr = 0; br = 0; jp = 0;
    case (op)
      'h37: begin ok = 1; wr = 1; rs1 = 0; alu = ALU_ADD; imm = longint'($signed({ins[31:12], 12'b0})); end
      'h17: begin ok = 1; wr = 1; alu = ALU_ADD; imm = longint'($signed({ins[31:12], 12'b0})); end
      'h6f: begin
        ok = 1; wr = 1; jp = 1; wb = 2; alu = ALU_ADD;
        imm = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      'h67: begin ok = (f3 == 0); wr = 1; jp = 1; wb = 2; alu = ALU_ADD; imm = longint'($signed(ins[31:20])); end
      'h63: begin
        ok = (f3 != 2) && (f3 != 3); br = 1;
        alu = (f3 < 2) ? ALU_SUB : (f3 < 6) ? ALU_SLT : ALU_SLTU;
        imm = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      'h03: begin ok = f3 inside {0, 1, 2, 4, 5}; wr = 1; mr = 1; wb = 1; alu = ALU_ADD; imm = longint'($signed(ins[31:20])); end
      'h23: begin ok = (f3 <= 2); mw = 1; alu = ALU_ADD; imm = longint'($signed({ins[31:25], ins[11:7]})); end
      'h13: begin
        wr = 1; alu = base_alu[f3];
        if (f3 == 1) begin ok = (f7 == 0); imm = longint'(ins[24:20]); end
        else if (f3 == 5) begin
          ok = (f7 == 0) || (f7 == 'h20); imm = longint'(ins[24:20]);
          if (f7 == 'h20) alu = ALU_SRA;
        end else begin ok = 1; imm = longint'($signed(ins[31:20])); end
      end
      'h33: begin
        wr = 1;
        if (f7 == 0) begin ok = 1; alu = base_alu[f3]; end
        else if (f7 == 'h20) begin ok = (f3 == 0) || (f3 == 5); alu = (f3 == 0) ? ALU_SUB : ALU_SRA; end
`ifdef DECODE_RV32M_EN
        else if (f7 == 1) begin ok = 1; alu = ALU_MUL + f3; end
`endif
        else ok = 0;
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      imm = 0; alu = ALU_NOP; wb = 0; wr = 0; mw = 0; mr = 0; br = 0; jp = 0;
    end
    return {pc, ins[6:0], ins[14:12], rs1, ins[24:20], rd, imm[31:0], 5'(alu), 2'(wb),
            wr && (rd != 5'd0), mw, mr, br, jp, !ok};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops[9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 11);
    if (k < 9) r[6:0] = ops[k];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    return r;
  endfunction

  // scoreboard compare
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    chk("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
    if (exp_q.size() > 0) chk("bundle", 128'(obs_bundle), 128'(exp_q[0]));
  endtask

  // driver: one clock of stimulus, scoreboard update at the edge, check after it
  task automatic cycle(input bit v, input logic [31:0] ins, input bit ordy, input bit fl);
    bit exp_rdy, acc;
    logic [31:0] pc;
    pc = pc_ctr;
    pc_ctr = pc_ctr + 32'd4;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = !rst && (exp_q.size() < 2);
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    if (rst || fl) exp_q.delete();
    else begin
      if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(ref_bundle(ins, pc));
    end
    #1;
    check_out();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    cycle(1, 32'h00000013, 1, 0);
    cycle(0, 32'h0, 1, 0);
    chk("reset_fields", 128'(obs_bundle), 128'(0));
    rst = 1'b0;

    // ADDI x1,x0,-1
    cycle(1, 32'hFFF00093, 1, 0);
    chk("addi_imm", 128'(out_imm), 128'(32'hFFFFFFFF));
    chk("addi_alu", 128'(out_alu_op), 128'(ALU_ADD));
    chk("addi_rd", 128'(out_rd), 128'(5'd1));
    chk("addi_we", 128'(out_reg_we), 128'(1'b1));

    // BEQ x0,x0,-4
    cycle(1, 32'hFE000EE3, 1, 0);
    chk("beq_imm", 128'(out_imm), 128'(32'hFFFFFFFC));
    chk("beq_branch", 128'(out_branch), 128'(1'b1));
    chk("beq_we", 128'(out_reg_we), 128'(1'b0));
    cycle(0, 32'h0, 1, 0);

    // back-pressure: A then B with out_ready low, then drain in order
    cycle(1, 32'h00500113, 0, 0);
    cycle(1, 32'h00A00193, 0, 0);
    chk("bp_in_ready_low", 128'(in_ready), 128'(1'b0));
    chk("bp_head_is_a", 128'(out_rd), 128'(5'd2));
    cycle(1, 32'h00F00213, 0, 0);
    cycle(0, 32'h0, 1, 0);
    chk("bp_head_is_b", 128'(out_rd), 128'(5'd3));
    cycle(0, 32'h0, 1, 0);
    chk("bp_in_ready_back", 128'(in_ready), 128'(1'b1));

    // flush while FULL with in_valid high, and flush alongside an accept
    cycle(1, 32'h00100093, 0, 0);
    cycle(1, 32'h00200113, 0, 0);
    cycle(1, 32'h00300193, 0, 1);
    chk("flush_full_valid", 128'(out_valid), 128'(1'b0));
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 1, 0);
    cycle(1, 32'h00100093, 0, 0);
    cycle(1, 32'h00200113, 1, 1);
    chk("flush_accept_valid", 128'(out_valid), 128'(1'b0));
    cycle(0, 32'h0, 1, 0);

    // illegal word and a write to x0
    cycle(1, 32'hFFFFFFFF, 1, 0);
    chk("ill_flag", 128'(out_illegal), 128'(1'b1));
    chk("ill_enables", 128'({out_reg_we, out_mem_we, out_mem_re, out_branch, out_jump}), 128'(0));
    chk("ill_alu", 128'(out_alu_op), 128'(ALU_NOP));
    cycle(1, 32'h00208033, 1, 0);
    chk("x0_we", 128'(out_reg_we), 128'(1'b0));
    chk("x0_legal", 128'(out_illegal), 128'(1'b0));

    // MUL x3,x1,x2
    cycle(1, 32'h022081B3, 1, 0);
`ifdef DECODE_RV32M_EN
    chk("mul_alu", 128'(out_alu_op), 128'(ALU_MUL));
    chk("mul_we", 128'(out_reg_we), 128'(1'b1));
`else
    chk("mul_illegal", 128'(out_illegal), 128'(1'b1));
`endif
    cycle(0, 32'h0, 1, 0);

    // reset with a full buffer discards everything
    cycle(1, 32'h00100093, 0, 0);
    cycle(1, 32'h00200113, 0, 0);
    rst = 1'b1;
    cycle(0, 32'h0, 0, 0);
    chk("midreset_fields", 128'(obs_bundle), 128'(0));
    rst = 1'b0;
    cycle(0, 32'h0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 39) == 0);
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
